regfile_sb: RTL and testbench

Parametrised general-purpose register file with integrated scoreboard for the multicycle RISC datapath. Generalises the 8×16 register file in data width, register count and hardwired-zero mode. Adds write-first bypass on its registered read ports and per-register busy tracking for in-flight destinations. Sits between decode (issue and read) and writeback; the control unit uses the busy flags to stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;

  // True when the address names the hardwired-zero register.
  function automatic logic is_zero_reg(input logic zero_en, input logic [31:0] addr);
    return zero_en && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy tracking for in-flight destinations: WAW conflict pulse and source-busy capture.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS   = DEF_NREGS,
  parameter int AW      = $clog2(NREGS),
  parameter int ZERO_R0 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic             we,
  input  logic [AW-1:0]    rw,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  output logic [NREGS-1:0] busy,
  output logic             ra_busy,
  output logic             rb_busy,
  output logic             iss_conflict
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] iss_hit;
  logic [NREGS-1:0] busy_pw;
  logic [NREGS-1:0] busy_d;

  // Issue/writeback protocol: iss_en reserves iss_rd, we releases rw; both are
  // single-cycle qualifiers with no back-pressure. When both hit one register
  // in the same cycle the fresh reservation wins.
  always_comb begin
    wb_hit  = '0;
    iss_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      wb_hit[i]  = we && (rw == AW'(i));
      iss_hit[i] = iss_en && (iss_rd == AW'(i)) && !is_zero_reg(ZERO_R0 != 0, i);
    end
    busy_pw = busy_q & ~wb_hit;
    busy_d  = busy_pw | iss_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      ra_busy      <= 1'b0;
      rb_busy      <= 1'b0;
      iss_conflict <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      iss_conflict <= |(iss_hit & busy_pw);
      // Sources see the post-writeback, pre-issue view.
      if (rd_en) begin
        ra_busy <= busy_pw[ra];
        rb_busy <= busy_pw[rb];
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-first bypass on registered read ports
// and an integrated busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREGS   = DEF_NREGS,
  parameter int AW      = $clog2(NREGS),
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              we,
  input  logic [AW-1:0]     rw,
  input  logic [DATA_W-1:0] busw,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_conflict,
  output logic [NREGS-1:0]  busy
);

  logic [DATA_W-1:0] mem [NREGS];
  logic              wr_ok;

  assign wr_ok = we && !is_zero_reg(ZERO_R0 != 0, 32'(rw));

  // Zero register beats bypass; bypass beats the stale array value.
  function automatic logic [DATA_W-1:0] src_val(input logic [AW-1:0] addr);
    if (is_zero_reg(ZERO_R0 != 0, 32'(addr)))
      return '0;
    else if (we && (rw == addr))
      return busw;
    else
      return mem[addr];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      busa <= '0;
      busb <= '0;
    end else begin
      if (rd_en) begin
        busa <= src_val(ra);
        busb <= src_val(rb);
      end
      if (wr_ok) mem[rw] <= busw;
    end
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .ra           (ra),
    .rb           (rb),
    .we           (we),
    .rw           (rw),
    .iss_en       (iss_en),
    .iss_rd       (iss_rd),
    .busy         (busy),
    .ra_busy      (ra_busy),
    .rb_busy      (rb_busy),
    .iss_conflict (iss_conflict)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_regfile_sb;

  localparam int DATA_W  = 16;
  localparam int NREGS   = 8;
  localparam int AW      = 3;
  localparam int ZERO_R0 = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     ra = '0;
  logic [AW-1:0]     rb = '0;
  logic [DATA_W-1:0] busa;
  logic [DATA_W-1:0] busb;
  logic              ra_busy;
  logic              rb_busy;
  logic              we = 1'b0;
  logic [AW-1:0]     rw = '0;
  logic [DATA_W-1:0] busw = '0;
  logic              iss_en = 1'b0;
  logic [AW-1:0]     iss_rd = '0;
  logic              iss_conflict;
  logic [NREGS-1:0]  busy;

  regfile_sb #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .ra           (ra),
    .rb           (rb),
    .busa         (busa),
    .busb         (busb),
    .ra_busy      (ra_busy),
    .rb_busy      (rb_busy),
    .we           (we),
    .rw           (rw),
    .busw         (busw),
    .iss_en       (iss_en),
    .iss_rd       (iss_rd),
    .iss_conflict (iss_conflict),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: register contents, busy set, and expected outputs
  logic [DATA_W-1:0] m_mem [NREGS];
  logic [NREGS-1:0]  m_busy;
  logic [DATA_W-1:0] e_busa, e_busb;
  logic              e_ra_busy, e_rb_busy, e_conf;
  bit                chk_on = 1'b0;

  function automatic logic [DATA_W-1:0] m_read(input int a);
    if (ZERO_R0 == 1 && a == 0) return '0;
    if (we && int'(rw) == a) return busw;
    return m_mem[a];
  endfunction

  function automatic logic m_src_busy(input int a);
    if (we && int'(rw) == a) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
      m_busy = '0;
      e_busa = '0; e_busb = '0;
      e_ra_busy = 1'b0; e_rb_busy = 1'b0; e_conf = 1'b0;
      chk_on = 1'b1;
    end else begin
      logic [NREGS-1:0] nb;
      logic             zero_iss;
      if (rd_en) begin
        e_busa    = m_read(int'(ra));
        e_busb    = m_read(int'(rb));
        e_ra_busy = m_src_busy(int'(ra));
        e_rb_busy = m_src_busy(int'(rb));
      end
      zero_iss = (ZERO_R0 == 1) && (iss_rd == 0);
      e_conf = iss_en && !zero_iss && m_src_busy(int'(iss_rd));
      nb = m_busy;
      if (we) nb[rw] = 1'b0;
      if (iss_en && !zero_iss) nb[iss_rd] = 1'b1;
      if (we && !(ZERO_R0 == 1 && rw == 0)) m_mem[rw] = busw;
      m_busy = nb;
    end
  end

  // one compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("busa", 32'(busa), 32'(e_busa));
      check("busb", 32'(busb), 32'(e_busb));
      check("ra_busy", 32'(ra_busy), 32'(e_ra_busy));
      check("rb_busy", 32'(rb_busy), 32'(e_rb_busy));
      check("iss_conflict", 32'(iss_conflict), 32'(e_conf));
      check("busy", 32'(busy), 32'(m_busy));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rd_en = 1'b0; we = 1'b0; iss_en = 1'b0; rst = 1'b0;
  endtask

  task automatic do_read(input int a, input int b);
    rd_en = 1'b1; ra = AW'(a); rb = AW'(b);
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    we = 1'b1; rw = AW'(a); busw = d;
  endtask

  task automatic do_issue(input int a);
    iss_en = 1'b1; iss_rd = AW'(a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset then read
    rst = 1'b1; cyc();
    idle(); do_read(3, 5); cyc();
    check("rst_busa", 32'(busa), 32'h0000);
    check("rst_busb", 32'(busb), 32'h0000);
    check("rst_busy", 32'(busy), 32'h00);

    // write then read
    idle(); do_write(1, 16'h5555); cyc();
    idle(); do_read(1, 0); cyc();
    check("wr_busa", 32'(busa), 32'h5555);
    check("wr_busb", 32'(busb), 32'h0000);

    // bypass, and zero register ignoring writes
    idle(); do_write(2, 16'h1234); do_read(2, 0); cyc();
    check("bypass_busa", 32'(busa), 32'h1234);
    idle(); do_write(0, 16'hAAAA); cyc();
    idle(); do_read(0, 2); cyc();
    check("r0_busa", 32'(busa), 32'h0000);
    check("r2_busb", 32'(busb), 32'h1234);
    idle(); do_write(0, 16'hAAAA); do_read(0, 0); cyc();
    check("r0_bypass", 32'(busa), 32'h0000);

    // scoreboard
    idle(); do_issue(4); cyc();
    check("iss4_busy", 32'(busy), 32'h10);
    idle(); do_read(4, 0); cyc();
    check("iss4_ra_busy", 32'(ra_busy), 32'h1);
    idle(); do_write(4, 16'hBEEF); cyc();
    check("wb4_busy", 32'(busy), 32'h00);
    idle(); do_read(4, 0); cyc();
    check("wb4_busa", 32'(busa), 32'hBEEF);
    check("wb4_ra_busy", 32'(ra_busy), 32'h0);

    // conflict
    idle(); do_issue(6); cyc();
    check("conf_first", 32'(iss_conflict), 32'h0);
    idle(); do_issue(6); cyc();
    check("conf_second", 32'(iss_conflict), 32'h1);
    idle(); cyc();
    check("conf_drop", 32'(iss_conflict), 32'h0);
    idle(); do_issue(6); do_write(6, 16'h6666); cyc();
    check("iss_wb_busy", 32'(busy), 32'h40);
    check("iss_wb_conf", 32'(iss_conflict), 32'h0);
    idle(); do_read(6, 0); cyc();
    check("iss_wb_data", 32'(busa), 32'h6666);
    check("iss_wb_ra_busy", 32'(ra_busy), 32'h1);
    idle(); do_issue(0); do_write(6, 16'h0606); cyc();
    check("iss0_busy", 32'(busy), 32'h00);
    check("iss0_conf", 32'(iss_conflict), 32'h0);

    // mid-operation reset drops the in-flight write
    idle(); do_issue(3); cyc();
    idle(); do_issue(4); cyc();
    check("pre_rst_busy", 32'(busy), 32'h18);
    idle(); rst = 1'b1; do_write(3, 16'hFFFF); do_read(3, 1); do_issue(5); cyc();
    check("mid_rst_busy", 32'(busy), 32'h00);
    check("mid_rst_busa", 32'(busa), 32'h0000);
    idle(); do_read(3, 1); cyc();
    check("post_rst_r3", 32'(busa), 32'h0000);
    check("post_rst_r1", 32'(busb), 32'h0000);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      idle();
      rst    = ($urandom_range(0, 99) == 0);
      rd_en  = $urandom_range(0, 1);
      ra     = AW'($urandom_range(0, NREGS - 1));
      rb     = AW'($urandom_range(0, NREGS - 1));
      we     = $urandom_range(0, 2) == 0;
      rw     = AW'($urandom_range(0, NREGS - 1));
      busw   = DATA_W'($urandom);
      iss_en = $urandom_range(0, 2) == 0;
      iss_rd = AW'($urandom_range(0, NREGS - 1));
      cyc();
    end
    idle(); cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
